serial_disp_rx: RTL and testbench

SERIAL_DISP_RX -- requirements
Module: serial_disp_rx

---
 rtl/serial_disp_rx.sv | 122 ++++++++++++
 tb/tb_serial_disp_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_disp_rx.sv
// Receiver for a display/LED style serial shifter (clock, data, latch, clear).
// Inputs are synchronized to clk, and each latched frame is presented on pdata with a one-cycle data_valid.
module serial_disp_rx #(
    parameter int WIDTH  = 16,
    parameter bit INVERT = 1'b1
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             s_clk,
    input  logic             s_dat,
    input  logic             s_pen,
    input  logic             s_clrn,
    output logic [WIDTH-1:0] pdata,
    output logic             data_valid,
    output logic             frame_err,
    output logic [5:0]       bit_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

    logic sclk_p0, sclk_p1, sclk_p2, sclk_evt_p3;
    logic pen_p0, pen_p1, pen_p2, pen_evt_p3;
    logic dat_p0, dat_p1;
    logic clrn_p0, clrn_p1;

    logic [WIDTH-1:0] shreg;
    state_t           state;

    logic [WIDTH-1:0] shreg_sh, shreg_now;
    logic [5:0]       cnt_sh;
    state_t           state_sh, state_now;

    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c == 6'd63) ? c : c + 6'd1;
    endfunction

    function automatic logic [WIDTH-1:0] polarity(input logic [WIDTH-1:0] v);
        return INVERT ? ~v : v;
    endfunction

    // Stage p0/p1: two-flop synchronizers; p2: delayed copy; p3: registered edge pulses
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            sclk_p0     <= 1'b0;
            sclk_p1     <= 1'b0;
            sclk_p2     <= 1'b0;
            sclk_evt_p3 <= 1'b0;
            pen_p0      <= 1'b0;
            pen_p1      <= 1'b0;
            pen_p2      <= 1'b0;
            pen_evt_p3  <= 1'b0;
            dat_p0      <= 1'b0;
            dat_p1      <= 1'b0;
            clrn_p0     <= 1'b0;
            clrn_p1     <= 1'b0;
        end else begin
            sclk_p0     <= s_clk;
            sclk_p1     <= sclk_p0;
            sclk_p2     <= sclk_p1;
            sclk_evt_p3 <= sclk_p1 & ~sclk_p2;
            pen_p0      <= s_pen;
            pen_p1      <= pen_p0;
            pen_p2      <= pen_p1;
            pen_evt_p3  <= pen_p1 & ~pen_p2;
            dat_p0      <= s_dat;
            dat_p1      <= dat_p0;
            clrn_p0     <= s_clrn;
            clrn_p1     <= clrn_p0;
        end
    end

    // Post-shift view of the frame, so a latch coinciding with a shift captures the new bit
    always_comb begin
        shreg_sh = (shreg << 1) | WIDTH'(dat_p1);
        cnt_sh   = sat_inc(bit_cnt);
        state_sh = state;
        case (state)
            IDLE:    state_sh = (WIDTH == 1) ? FULL : SHIFT;
            SHIFT:   state_sh = (cnt_sh == 6'(WIDTH)) ? FULL : SHIFT;
            FULL:    state_sh = OVER;
            default: state_sh = OVER;
        endcase
        shreg_now = sclk_evt_p3 ? shreg_sh : shreg;
        state_now = sclk_evt_p3 ? state_sh : state;
    end

    // Stage p4: frame FSM and output registers; clear has priority over latch and shift
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            shreg      <= '0;
            bit_cnt    <= 6'd0;
            state      <= IDLE;
            busy       <= 1'b0;
            pdata      <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (!clrn_p1) begin
                shreg   <= '0;
                bit_cnt <= 6'd0;
                state   <= IDLE;
                busy    <= 1'b0;
            end else if (pen_evt_p3) begin
                pdata      <= polarity(shreg_now);
                frame_err  <= (state_now != FULL);
                data_valid <= 1'b1;
                shreg      <= '0;
                bit_cnt    <= 6'd0;
                state      <= IDLE;
                busy       <= 1'b0;
            end else if (sclk_evt_p3) begin
                shreg   <= shreg_sh;
                bit_cnt <= cnt_sh;
                state   <= state_sh;
                busy    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_disp_rx.sv
// Scoreboard bench for serial_disp_rx (WIDTH=16, INVERT=1) against a bit-queue frame model.
module tb_serial_disp_rx;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         RSTN, s_clk, s_dat, s_pen, s_clrn;
    logic [W-1:0] pdata;
    logic         data_valid, frame_err, busy;
    logic [5:0]   bit_cnt;

    always #5 clk = ~clk;

    serial_disp_rx #(.WIDTH(W), .INVERT(1'b1)) dut (
        .clk(clk), .RSTN(RSTN), .s_clk(s_clk), .s_dat(s_dat), .s_pen(s_pen),
        .s_clrn(s_clrn), .pdata(pdata), .data_valid(data_valid),
        .frame_err(frame_err), .bit_cnt(bit_cnt), .busy(busy)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   model_q[$];
    exp_t sb[$];
    exp_t mon_e;
    logic last_err = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: the frame is the last W bits received, first-sent bit most significant
    task automatic model_latch();
        logic [W-1:0] v;
        int n, start;
        exp_t e;
        v = '0;
        n = model_q.size();
        start = (n > W) ? n - W : 0;
        for (int i = start; i < n; i++) v = {v[W-2:0], model_q[i]};
        e.d = ~v;
        e.e = (n != W);
        sb.push_back(e);
        model_q.delete();
    endtask

    task automatic send_bit(input bit b);
        s_dat = b;
        wait_cyc(2);
        s_clk = 1'b1;
        model_q.push_back(b);
        wait_cyc(5);
        s_clk = 1'b0;
        wait_cyc(5);
    endtask

    task automatic send_word(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) send_bit(t[i]);
    endtask

    function automatic int exp_cnt();
        return (model_q.size() > 63) ? 63 : model_q.size();
    endfunction

    task automatic pen_pulse(input bit with_clk, input bit b);
        int lat;
        if (with_clk) begin
            s_dat = b;
            wait_cyc(2);
            s_clk = 1'b1;
            model_q.push_back(b);
        end
        s_pen = 1'b1;
        model_latch();
        lat = 0;
        while (lat < 20 && data_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("pen_to_valid_latency", lat, 4);
        wait_cyc(4);
        s_pen = 1'b0;
        s_clk = 1'b0;
        wait_cyc(5);
        check("bit_cnt_after_latch", bit_cnt, 0);
        check("busy_after_latch", busy, 0);
    endtask

    always @(negedge clk) begin
        if (RSTN === 1'b1 && data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got data_valid=1 pdata=0x%0h expected no output at %0t", pdata, $time);
            end else begin
                mon_e = sb.pop_front();
                check("pdata", pdata, mon_e.d);
                check("frame_err", frame_err, mon_e.e);
                last_err = mon_e.e;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wc;
        int len;
        RSTN = 1'b0; s_clk = 1'b0; s_dat = 1'b0; s_pen = 1'b0; s_clrn = 1'b1;
        wait_cyc(4);
        check("rst_pdata", pdata, 0);
        check("rst_valid", data_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_busy", busy, 0);
        RSTN = 1'b1;
        wait_cyc(4);

        // Exact 16-bit frame
        send_word(32'h5A3C, 16);
        check("full_bit_cnt", bit_cnt, 16);
        check("full_busy", busy, 1);
        pen_pulse(1'b0, 1'b0);

        // Short frame
        send_word(32'hABC, 12);
        check("short_bit_cnt", bit_cnt, 12);
        check("err_hold", frame_err, last_err);
        pen_pulse(1'b0, 1'b0);

        // Overrun: last 16 bits kept
        send_word(32'hFFFF1, 20);
        check("over_bit_cnt", bit_cnt, 20);
        check("over_busy", busy, 1);
        check("err_hold_over", frame_err, last_err);
        pen_pulse(1'b0, 1'b0);

        // Clear mid-frame, latch attempt while cleared is ignored
        send_word(32'h96, 8);
        s_clrn = 1'b0;
        model_q.delete();
        wait_cyc(4);
        check("clr_bit_cnt", bit_cnt, 0);
        check("clr_busy", busy, 0);
        s_pen = 1'b1;
        wait_cyc(6);
        s_pen = 1'b0;
        wait_cyc(6);
        s_clrn = 1'b1;
        wait_cyc(4);
        send_word(32'h1234, 16);
        pen_pulse(1'b0, 1'b0);

        // Latch coincident with the 16th shift edge
        send_word(32'hBEEF >> 1, 15);
        pen_pulse(1'b1, 1'b1);

        // Latch with nothing shifted
        pen_pulse(1'b0, 1'b0);

        // Reset mid-frame, then a clean frame
        send_word(32'h55, 7);
        RSTN = 1'b0;
        wait_cyc(1);
        check("midrst_pdata", pdata, 0);
        check("midrst_valid", data_valid, 0);
        check("midrst_err", frame_err, 0);
        check("midrst_bit_cnt", bit_cnt, 0);
        check("midrst_busy", busy, 0);
        model_q.delete();
        wait_cyc(2);
        RSTN = 1'b1;
        wait_cyc(4);
        send_word(32'hC3A5, 16);
        pen_pulse(1'b0, 1'b0);

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(0, 24);
            for (int i = 0; i < len; i++) send_bit(1'($urandom_range(0, 1)));
            check("rand_bit_cnt", bit_cnt, exp_cnt());
            wc = 1'($urandom_range(0, 1));
            pen_pulse(wc, 1'($urandom_range(0, 1)));
        end

        wait_cyc(10);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
